// File: rtl/lpc_record_serializer.sv
// Pops DW-bit records from a ringbuffer and sends each one to a UART as uppercase ASCII hex, MSB nibble first.
// Define SERIALIZER_CRLF_EN to end every record with CR LF.
module lpc_record_serializer #(
    parameter int DW = 48
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          empty,
    output logic          read_clock_enable,
    input  logic [DW-1:0] read_data,
    input  logic          uart_ready,
    output logic          uart_write,
    output logic [7:0]    uart_data,
    output logic          busy,
    output logic [15:0]   records_sent,
    output logic [2:0]    dbg_state
);

    // Byte handshake: uart_write/uart_data are held unchanged until an edge
    // where uart_write=1 and uart_ready=1; uart_ready is ignored otherwise.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        LATCH    = 3'd2,
        SEND_HEX = 3'd3,
        SEND_CR  = 3'd4,
        SEND_LF  = 3'd5
    } state_t;

    localparam logic [4:0] NIBBLES = 5'(DW / 4);

    state_t        state, state_nxt;
    logic [DW-1:0] shift_q;
    logic [4:0]    nib_cnt;
    logic [15:0]   sent_cnt;
    logic          last_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        read_clock_enable = 1'b0;
        uart_write        = 1'b0;
        uart_data         = 8'h00;
        last_byte         = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) state_nxt = FETCH;
            end
            FETCH: begin
                read_clock_enable = 1'b1;
                state_nxt         = LATCH;
            end
            LATCH: begin
                state_nxt = SEND_HEX;
            end
            SEND_HEX: begin
                uart_write = 1'b1;
                uart_data  = hex_ascii(shift_q[DW-1 -: 4]);
                if (uart_ready && nib_cnt == 5'd1) begin
`ifdef SERIALIZER_CRLF_EN
                    state_nxt = SEND_CR;
`else
                    last_byte = 1'b1;
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef SERIALIZER_CRLF_EN
            SEND_CR: begin
                uart_write = 1'b1;
                uart_data  = 8'h0D;
                if (uart_ready) state_nxt = SEND_LF;
            end
            SEND_LF: begin
                uart_write = 1'b1;
                uart_data  = 8'h0A;
                if (uart_ready) begin
                    last_byte = 1'b1;
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // read_data is valid during LATCH, one cycle after the pop pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q  <= '0;
            nib_cnt  <= 5'd0;
            sent_cnt <= 16'h0000;
        end else begin
            if (state == LATCH) begin
                shift_q <= read_data;
                nib_cnt <= NIBBLES;
            end else if (state == SEND_HEX && uart_ready) begin
                shift_q <= {shift_q[DW-5:0], 4'h0};
                nib_cnt <= nib_cnt - 5'd1;
            end
            if (last_byte) sent_cnt <= sent_cnt + 16'h0001;
        end
    end

    assign busy         = (state != IDLE);
    assign records_sent = sent_cnt;
    assign dbg_state    = state;

endmodule

// File: tb/tb_lpc_record_serializer.sv
// Directed bench for lpc_record_serializer: ringbuffer model, UART sink log and per-scenario checks.
module tb_lpc_record_serializer;

    localparam int DW = 48;
`ifdef SERIALIZER_CRLF_EN
    localparam int NB = DW / 4 + 2;
`else
    localparam int NB = DW / 4;
`endif

    logic          clock;
    logic          reset;
    logic          empty;
    logic          read_clock_enable;
    logic [DW-1:0] read_data;
    logic          uart_ready;
    logic          uart_write;
    logic [7:0]    uart_data;
    logic          busy;
    logic [15:0]   records_sent;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] rb_q[$];
    logic [7:0]    xfer_q[$];
    int            xfer_cyc_q[$];
    int            pop_cyc_q[$];
    logic [7:0]    exp_q[$];

    lpc_record_serializer #(.DW(DW)) dut (
        .clock(clock),
        .reset(reset),
        .empty(empty),
        .read_clock_enable(read_clock_enable),
        .read_data(read_data),
        .uart_ready(uart_ready),
        .uart_write(uart_write),
        .uart_data(uart_data),
        .busy(busy),
        .records_sent(records_sent),
        .dbg_state(dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One cycle: sample at the falling edge, apply ringbuffer effects just after the rising edge.
    task automatic tick();
        logic          do_pop;
        logic [DW-1:0] nd;
        @(negedge clock);
        do_pop = 1'b0;
        nd     = '0;
        if (read_clock_enable) begin
            pop_cyc_q.push_back(cyc);
            if (rb_q.size() > 0) begin
                nd     = rb_q.pop_front();
                do_pop = 1'b1;
            end
        end
        if (uart_write && uart_ready) begin
            xfer_q.push_back(uart_data);
            xfer_cyc_q.push_back(cyc);
        end
        @(posedge clock);
        #1;
        cyc++;
        if (do_pop) read_data = nd;
        empty = (rb_q.size() == 0);
    endtask

    task automatic push_rec(input logic [DW-1:0] rec);
        rb_q.push_back(rec);
        empty = 1'b0;
    endtask

    task automatic clear_logs();
        xfer_q.delete();
        xfer_cyc_q.delete();
        pop_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic load_exp(input logic [DW-1:0] rec);
        logic [3:0] n;
        for (int i = DW / 4 - 1; i >= 0; i--) begin
            n = rec[i*4 +: 4];
            exp_q.push_back((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10));
        end
`ifdef SERIALIZER_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic run_until_xfers(input int n, input int bound, input string name);
        int k = 0;
        while (xfer_q.size() < n && k < bound) begin
            tick();
            k++;
        end
        checks++;
        if (xfer_q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: transfers=%0d required=%0d", name, xfer_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        empty = 1'b1;
        uart_ready = 1'b1;
        read_data = '0;
        repeat (3) tick();
        checks++; if (read_clock_enable !== 1'b0) begin errors++; $display("FAIL reset_rce: got=%b exp=0", read_clock_enable); end
        checks++; if (uart_write !== 1'b0) begin errors++; $display("FAIL reset_write: got=%b exp=0", uart_write); end
        checks++; if (uart_data !== 8'h00) begin errors++; $display("FAIL reset_data: got=%h exp=00", uart_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got=%b exp=0", busy); end
        checks++; if (records_sent !== 16'h0000) begin errors++; $display("FAIL reset_count: got=%h exp=0000", records_sent); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got=%0d exp=0", dbg_state); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_idle_empty();
        int rce_seen = 0;
        int busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (read_clock_enable) rce_seen++;
            if (busy) busy_seen++;
        end
        checks++; if (rce_seen != 0) begin errors++; $display("FAIL idle_rce: got=%0d pulses exp=0", rce_seen); end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL idle_busy: got=%0d busy cycles exp=0", busy_seen); end
    endtask

    task automatic test_single_record();
        logic [7:0] hex_tbl[12] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                                    8'h36, 8'h37, 8'h38, 8'h39, 8'h41, 8'h42};
        clear_logs();
        uart_ready = 1'b1;
        push_rec(48'h0123456789AB);
        run_until_xfers(NB, 60, "single");
        tick();
        checks++; if (xfer_q.size() != NB) begin errors++; $display("FAIL single_count: got=%0d bytes exp=%0d", xfer_q.size(), NB); end
        for (int i = 0; i < NB && i < xfer_q.size(); i++) begin
            logic [7:0] e;
            e = (i < 12) ? hex_tbl[i] : ((i == 12) ? 8'h0D : 8'h0A);
            checks++;
            if (xfer_q[i] !== e) begin errors++; $display("FAIL single_byte%0d: got=%h exp=%h", i, xfer_q[i], e); end
        end
        for (int i = 1; i < xfer_cyc_q.size(); i++) begin
            checks++;
            if (xfer_cyc_q[i] != xfer_cyc_q[i-1] + 1) begin errors++; $display("FAIL single_gap%0d: cycle=%0d exp=%0d", i, xfer_cyc_q[i], xfer_cyc_q[i-1] + 1); end
        end
        if (pop_cyc_q.size() > 0 && xfer_cyc_q.size() > 0) begin
            checks++;
            if (xfer_cyc_q[0] != pop_cyc_q[0] + 2) begin errors++; $display("FAIL single_latency: first byte cycle=%0d exp=%0d", xfer_cyc_q[0], pop_cyc_q[0] + 2); end
        end
        checks++; if (pop_cyc_q.size() != 1) begin errors++; $display("FAIL single_pops: got=%0d exp=1", pop_cyc_q.size()); end
        checks++; if (records_sent !== 16'd1) begin errors++; $display("FAIL single_sent: got=%h exp=0001", records_sent); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got=%b exp=0", busy); end
    endtask

    task automatic test_stall();
        int k = 0;
        clear_logs();
        uart_ready = 1'b0;
        push_rec(48'hF00000000000);
        load_exp(48'hF00000000000);
        while (!uart_write && k < 10) begin tick(); k++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (uart_write !== 1'b1 || uart_data !== 8'h46) begin
                errors++;
                $display("FAIL stall_hold%0d: write=%b data=%h exp write=1 data=46", i, uart_write, uart_data);
            end
            tick();
        end
        checks++; if (xfer_q.size() != 0) begin errors++; $display("FAIL stall_no_xfer: got=%0d transfers exp=0", xfer_q.size()); end
        uart_ready = 1'b1;
        run_until_xfers(NB, 60, "stall");
        tick();
        checks++; if (xfer_q.size() != NB) begin errors++; $display("FAIL stall_count: got=%0d bytes exp=%0d", xfer_q.size(), NB); end
        for (int i = 0; i < NB && i < xfer_q.size(); i++) begin
            checks++;
            if (xfer_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte%0d: got=%h exp=%h", i, xfer_q[i], exp_q[i]); end
        end
        checks++; if (records_sent !== 16'd2) begin errors++; $display("FAIL stall_sent: got=%h exp=0002", records_sent); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        uart_ready = 1'b1;
        push_rec(48'hFFFFFFFFFFFF);
        push_rec(48'h000000000000);
        load_exp(48'hFFFFFFFFFFFF);
        load_exp(48'h000000000000);
        run_until_xfers(2 * NB, 120, "b2b");
        tick();
        checks++; if (pop_cyc_q.size() != 2) begin errors++; $display("FAIL b2b_pops: got=%0d exp=2", pop_cyc_q.size()); end
        if (pop_cyc_q.size() >= 2 && xfer_cyc_q.size() >= NB) begin
            checks++;
            if (pop_cyc_q[1] <= xfer_cyc_q[NB-1]) begin
                errors++;
                $display("FAIL b2b_order: second pop cycle=%0d exp after %0d", pop_cyc_q[1], xfer_cyc_q[NB-1]);
            end
        end
        for (int i = 0; i < 2 * NB && i < xfer_q.size(); i++) begin
            checks++;
            if (xfer_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got=%h exp=%h", i, xfer_q[i], exp_q[i]); end
        end
        checks++; if (records_sent !== 16'd4) begin errors++; $display("FAIL b2b_sent: got=%h exp=0004", records_sent); end
    endtask

    task automatic test_reset_mid_record();
        clear_logs();
        uart_ready = 1'b1;
        push_rec(48'h123456789ABC);
        run_until_xfers(4, 30, "midrst_pre");
        reset = 1'b0;
        #1;
        checks++; if (uart_write !== 1'b0) begin errors++; $display("FAIL midrst_write: got=%b exp=0", uart_write); end
        checks++; if (uart_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got=%h exp=00", uart_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got=%b exp=0", busy); end
        checks++; if (read_clock_enable !== 1'b0) begin errors++; $display("FAIL midrst_rce: got=%b exp=0", read_clock_enable); end
        checks++; if (records_sent !== 16'h0000) begin errors++; $display("FAIL midrst_sent: got=%h exp=0000", records_sent); end
        tick();
        tick();
        clear_logs();
        push_rec(48'hDEF012345678);
        load_exp(48'hDEF012345678);
        reset = 1'b1;
        run_until_xfers(NB, 60, "midrst_post");
        tick();
        checks++; if (xfer_q.size() > 0 && xfer_q[0] !== 8'h44) begin errors++; $display("FAIL midrst_first: got=%h exp=44", xfer_q[0]); end
        for (int i = 0; i < NB && i < xfer_q.size(); i++) begin
            checks++;
            if (xfer_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_byte%0d: got=%h exp=%h", i, xfer_q[i], exp_q[i]); end
        end
        checks++; if (records_sent !== 16'd1) begin errors++; $display("FAIL midrst_count: got=%h exp=0001", records_sent); end
    endtask

    task automatic test_wrap();
        force dut.sent_cnt = 16'hFFFE;
        #1;
        release dut.sent_cnt;
        clear_logs();
        uart_ready = 1'b1;
        push_rec(48'hA5A5A5A5A5A5);
        run_until_xfers(NB, 60, "wrap_first");
        tick();
        checks++; if (records_sent !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got=%h exp=ffff", records_sent); end
        push_rec(48'h5A5A5A5A5A5A);
        run_until_xfers(2 * NB, 60, "wrap_second");
        tick();
        checks++; if (records_sent !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got=%h exp=0000", records_sent); end
    endtask

    initial begin
        test_reset();
        test_idle_empty();
        test_single_record();
        test_stall();
        test_back_to_back();
        test_reset_mid_record();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
